cpu_cycle_sequencer: RTL

Generates the T-state and M-cycle timing vectors that every instruction microcode unit consumes. It produces a one-hot T-state step and a one-hot M-cycle count, plus the active qualifier the microcode units use. It closes each instruction on the microcode's IR-fetch request and restarts timing for the next opcode. It sits in the control unit between the opcode decoder and the per-instruction microcode ROM-equivalents; it is the timing source for their `i_Cycle_Step`, `i_Cycle_Count` and `i_Active` inputs.

---
 rtl/cpu_cycle_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cpu_cycle_sequencer.sv
// rtl/cpu_cycle_sequencer.sv - T-state / M-cycle timing generator for the microcode units
//
// Ports:
//   i_Clk, i_Reset       core clock (one T-state per edge), synchronous active-high reset
//   i_IR_Fetch           current M-cycle is the instruction's last (overlapped fetch)
//   i_Wait               bus stall, honoured only at the T4 boundary
//   i_Halt_Req           HALT opcode executing (used only with CPU_CYCLE_SEQ_HALT_EN)
//   i_Int_Pending        wakes from HALT (used only with CPU_CYCLE_SEQ_HALT_EN)
//   o_Cycle_Step[3:0]    one-hot T-state, bit0 = T1
//   o_Cycle_Count[7:0]   one-hot M-cycle, bit0 = M1
//   o_Active             microcode qualifier
//   o_Opcode_Load        one-T-state pulse to latch the fetched opcode
//   o_Halted             HALT indicator
//   o_Sequence_Error     sticky: instruction ran past M8 without a fetch
// Optional feature macro: CPU_CYCLE_SEQ_HALT_EN

module cpu_cycle_sequencer (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_IR_Fetch,
    input  logic       i_Wait,
    input  logic       i_Halt_Req,
    input  logic       i_Int_Pending,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic       o_Active,
    output logic       o_Opcode_Load,
    output logic       o_Halted,
    output logic       o_Sequence_Error
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t     state_q, state_nxt;
    logic [3:0] step_q, step_nxt;
    logic [7:0] count_q, count_nxt;
    logic       active_q, active_nxt;
    logic       load_q, load_nxt;
    logic       err_q, err_nxt;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q  <= ST_RUN;
            step_q   <= 4'b0001;
            count_q  <= 8'b0000_0001;
            active_q <= 1'b0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            step_q   <= step_nxt;
            count_q  <= count_nxt;
            active_q <= active_nxt;
            load_q   <= load_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        step_nxt  = {step_q[2:0], step_q[3]};
        count_nxt = count_q;
        load_nxt  = 1'b0;
        err_nxt   = err_q;

        case (state_q)
            // STALL always sits at T4, so step_q[3] is the boundary in both states.
            ST_RUN, ST_STALL: begin
                if (step_q[3]) begin
                    if (i_Wait) begin
                        state_nxt = ST_STALL;
                        step_nxt  = step_q;
                    end else begin
                        state_nxt = ST_RUN;
                        if (i_IR_Fetch) begin
                            count_nxt = 8'b0000_0001;
`ifdef CPU_CYCLE_SEQ_HALT_EN
                            if (i_Halt_Req) begin
                                state_nxt = ST_HALTED;
                            end else begin
                                load_nxt = 1'b1;
                            end
`else
                            load_nxt = 1'b1;
`endif
                        end else if (count_q[7]) begin
                            // Runaway instruction: force a refetch and flag it.
                            count_nxt = 8'b0000_0001;
                            err_nxt   = 1'b1;
                            load_nxt  = 1'b1;
                        end else begin
                            count_nxt = {count_q[6:0], 1'b0};
                        end
                    end
                end
            end
`ifdef CPU_CYCLE_SEQ_HALT_EN
            ST_HALTED: begin
                // Step keeps rotating so the wake-up lands on a clean T4 boundary.
                if (step_q[3] && i_Int_Pending) begin
                    state_nxt = ST_RUN;
                    count_nxt = 8'b0000_0001;
                    load_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = ST_RUN;
                step_nxt  = 4'b0001;
                count_nxt = 8'b0000_0001;
            end
        endcase

        active_nxt = (state_nxt != ST_HALTED);
    end

`ifdef CPU_CYCLE_SEQ_HALT_EN
    assign o_Halted = (state_q == ST_HALTED);
`else
    logic unused_halt_inputs;
    assign unused_halt_inputs = i_Halt_Req ^ i_Int_Pending;
    assign o_Halted = 1'b0;
`endif

    assign o_Cycle_Step     = step_q;
    assign o_Cycle_Count    = count_q;
    assign o_Active         = active_q;
    assign o_Opcode_Load    = load_q;
    assign o_Sequence_Error = err_q;

endmodule
